// File: rtl/control_sequencer_if.sv
// Control bus between the instruction sequencer and the register/ALU datapath.
// The master modport is the sequencer side; the slave modport is the datapath side.
interface control_sequencer_if;
    logic        run;
    logic [15:0] current_instruction;
    logic [15:0] zeroflag;
    logic [15:0] signflag;
    logic [15:0] errorbit;
    logic        vga_ready;

    logic [3:0]  alu_op;
    logic [15:0] alu_a_altern;
    logic [15:0] alu_b_altern;
    logic [3:0]  alu_a_select;
    logic [3:0]  alu_b_select;
    logic        alu_a_source;
    logic        alu_b_source;
    logic [3:0]  alu_out_select;
    logic [1:0]  alu_load_src;
    logic        alu_store_to_mem;
    logic        alu_store_to_stk;
    logic        program_counter_increment;
    logic [3:0]  vga_color_select;
    logic [3:0]  vga_coord_select;
    logic        vga_plot;
    logic        halted;
    logic        fault;

    modport master (
        input  run, current_instruction, zeroflag, signflag, errorbit, vga_ready,
        output alu_op, alu_a_altern, alu_b_altern, alu_a_select, alu_b_select,
               alu_a_source, alu_b_source, alu_out_select, alu_load_src,
               alu_store_to_mem, alu_store_to_stk, program_counter_increment,
               vga_color_select, vga_coord_select, vga_plot, halted, fault
    );

    modport slave (
        output run, current_instruction, zeroflag, signflag, errorbit, vga_ready,
        input  alu_op, alu_a_altern, alu_b_altern, alu_a_select, alu_b_select,
               alu_a_source, alu_b_source, alu_out_select, alu_load_src,
               alu_store_to_mem, alu_store_to_stk, program_counter_increment,
               vga_color_select, vga_coord_select, vga_plot, halted, fault
    );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute/writeback sequencer driving the datapath controls.
// Every control output is registered so it is stable across the datapath's negedge sample.
module control_sequencer #(
    parameter logic [3:0] OP_PASS_A = 4'hF,
    parameter logic [3:0] OP_ADD    = 4'h0
) (
    input  logic                 clock,
    input  logic                 resetn,
    control_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEMWAIT, S_PLOTWAIT, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] I_LOADI = 4'h8, I_LOAD = 4'h9, I_STORE = 4'hA, I_PUSH = 4'hB,
                           I_BRZ   = 4'hC, I_BRN  = 4'hD, I_PLOT  = 4'hE, I_HALT = 4'hF;

    state_t      r_state;
    logic [3:0]  r_op, r_d;
    logic        r_taken;
    logic [3:0]  r_alu_op, r_a_sel, r_b_sel, r_out_sel, r_vga_color, r_vga_coord;
    logic [15:0] r_a_alt;
    logic        r_a_src, r_b_src;
    logic [1:0]  r_load_src;
    logic        r_st_mem, r_st_stk, r_pc_inc, r_plot, r_halted, r_fault;

    logic [3:0]  w_fop, w_fd, w_fa, w_fb;
    assign w_fop = bus.current_instruction[15:12];
    assign w_fd  = bus.current_instruction[11:8];
    assign w_fa  = bus.current_instruction[7:4];
    assign w_fb  = bus.current_instruction[3:0];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_d         <= '0;
            r_taken     <= 1'b0;
            r_alu_op    <= '0;
            r_a_sel     <= '0;
            r_b_sel     <= '0;
            r_out_sel   <= '0;
            r_vga_color <= '0;
            r_vga_coord <= '0;
            r_a_alt     <= '0;
            r_a_src     <= 1'b0;
            r_b_src     <= 1'b0;
            r_load_src  <= 2'b00;
            r_st_mem    <= 1'b0;
            r_st_stk    <= 1'b0;
            r_pc_inc    <= 1'b0;
            r_plot      <= 1'b0;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.run) r_state <= S_FETCH;
                S_FETCH: begin
                    // Decode straight from the bus so selects are already valid during DECODE.
                    r_op        <= w_fop;
                    r_d         <= w_fd;
                    r_taken     <= 1'b0;
                    r_alu_op    <= OP_PASS_A;
                    r_a_sel     <= w_fa;
                    r_b_sel     <= w_fb;
                    r_out_sel   <= w_fd;
                    r_a_alt     <= '0;
                    r_a_src     <= 1'b0;
                    r_b_src     <= 1'b0;
                    r_vga_color <= '0;
                    r_vga_coord <= '0;
                    case (w_fop)
                        I_LOADI: begin
                            r_a_alt <= {8'h00, bus.current_instruction[7:0]};
                            r_a_src <= 1'b1;
                        end
                        I_LOAD, I_STORE, I_PUSH: begin
                            r_alu_op <= OP_ADD;
                            r_b_src  <= 1'b1;
                        end
                        I_BRZ, I_BRN: r_out_sel <= 4'h0;
                        I_PLOT: begin
                            r_vga_color <= w_fd;
                            r_vga_coord <= w_fa;
                        end
                        I_HALT: ;
                        default: r_alu_op <= {1'b0, w_fop[2:0]};
                    endcase
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    case (r_op)
                        I_LOAD:  r_load_src <= 2'b10;
                        I_STORE: r_st_mem   <= 1'b1;
                        I_PUSH:  r_st_stk   <= 1'b1;
                        I_BRZ: if (bus.zeroflag[r_d]) begin
                            r_load_src <= 2'b01;
                            r_taken    <= 1'b1;
                        end
                        I_BRN: if (bus.signflag[r_d]) begin
                            r_load_src <= 2'b01;
                            r_taken    <= 1'b1;
                        end
                        I_PLOT, I_HALT: ;
                        default: r_load_src <= 2'b01;
                    endcase
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_st_mem <= 1'b0;
                    r_st_stk <= 1'b0;
                    case (r_op)
                        I_LOAD: r_state <= S_MEMWAIT;
                        I_PLOT: begin
                            r_plot  <= 1'b1;
                            r_state <= S_PLOTWAIT;
                        end
                        I_HALT: begin
                            r_load_src <= 2'b00;
                            r_halted   <= 1'b1;
                            r_state    <= S_HALT;
                        end
                        default: begin
                            r_load_src <= 2'b00;
                            r_pc_inc   <= !r_taken;
                            r_state    <= S_WB;
                        end
                    endcase
                end
                S_MEMWAIT: begin
                    r_load_src <= 2'b00;
                    r_pc_inc   <= 1'b1;
                    r_state    <= S_WB;
                end
                S_PLOTWAIT: if (bus.vga_ready) begin
                    r_plot   <= 1'b0;
                    r_pc_inc <= 1'b1;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    r_pc_inc <= 1'b0;
                    if (!r_op[3] && bus.errorbit[r_d]) begin
                        r_halted <= 1'b1;
                        r_fault  <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_state <= bus.run ? S_FETCH : S_IDLE;
                    end
                end
                S_HALT: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.alu_op                    = r_alu_op;
    assign bus.alu_a_altern              = r_a_alt;
    assign bus.alu_b_altern              = 16'h0000;
    assign bus.alu_a_select              = r_a_sel;
    assign bus.alu_b_select              = r_b_sel;
    assign bus.alu_a_source              = r_a_src;
    assign bus.alu_b_source              = r_b_src;
    assign bus.alu_out_select            = r_out_sel;
    assign bus.alu_load_src              = r_load_src;
    assign bus.alu_store_to_mem          = r_st_mem;
    assign bus.alu_store_to_stk          = r_st_stk;
    assign bus.program_counter_increment = r_pc_inc;
    assign bus.vga_color_select          = r_vga_color;
    assign bus.vga_coord_select          = r_vga_coord;
    assign bus.vga_plot                  = r_plot;
    assign bus.halted                    = r_halted;
    assign bus.fault                     = r_fault;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed plus randomized checks of control_sequencer against a per-instruction
// cycle-trace model built from the instruction set's timing rules.
module tb_control_sequencer;
    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    control_sequencer_if bus();
    control_sequencer dut (.clock(clock), .resetn(resetn), .bus(bus));

    typedef struct packed {
        logic [1:0] ls;
        logic sm, ss, pc, plot, halted, fault;
    } strb_t;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic strb_t obs();
        strb_t s;
        s.ls     = bus.alu_load_src;
        s.sm     = bus.alu_store_to_mem;
        s.ss     = bus.alu_store_to_stk;
        s.pc     = bus.program_counter_increment;
        s.plot   = bus.vga_plot;
        s.halted = bus.halted;
        s.fault  = bus.fault;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic restart();
        resetn  = 1'b0;
        bus.run = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_strobes", 32'(obs()), 32'h0);
        chk("reset_selects", {bus.alu_op, bus.alu_out_select, bus.alu_a_select, bus.vga_color_select},
            32'h0);
        resetn  = 1'b1;
        bus.run = 1'b1;
    endtask

    // Runs one instruction starting from its FETCH cycle. The expected trace is a list
    // of strobe words, one per cycle, derived from the opcode's documented latency.
    task automatic do_instr(input logic [15:0] ins, input logic [15:0] zf, input logic [15:0] sf,
                            input logic [15:0] eb, input int wt, input bit drop_run,
                            output bit stopped);
        strb_t q[$];
        strb_t e;
        logic [3:0] op, d, a, b;
        bit taken;
        int plot0;
        op = ins[15:12]; d = ins[11:8]; a = ins[7:4]; b = ins[3:0];
        taken   = (op == 4'hC && zf[d]) || (op == 4'hD && sf[d]);
        stopped = 1'b0;
        plot0   = 3;
        q.push_back('0);
        q.push_back('0);
        e = '0;
        if (op <= 4'h8) e.ls = 2'b01;
        else if (op == 4'h9) e.ls = 2'b10;
        else if (op == 4'hA) e.sm = 1'b1;
        else if (op == 4'hB) e.ss = 1'b1;
        else if (taken) e.ls = 2'b01;
        q.push_back(e);
        if (op == 4'hF) begin
            e = '0; e.halted = 1'b1;
            repeat (4) q.push_back(e);
            stopped = 1'b1;
        end else begin
            if (op == 4'h9) begin
                e = '0; e.ls = 2'b10; q.push_back(e);
            end
            if (op == 4'hE) begin
                e = '0; e.plot = 1'b1;
                repeat (wt + 1) q.push_back(e);
            end
            e = '0; e.pc = !taken; q.push_back(e);
            if (!op[3] && eb[d]) begin
                e = '0; e.halted = 1'b1; e.fault = 1'b1;
                repeat (3) q.push_back(e);
                stopped = 1'b1;
            end
        end
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clock);
            if (i == 0) begin
                bus.current_instruction = ins;
                bus.zeroflag = zf;
                bus.signflag = sf;
                bus.errorbit = eb;
            end
            chk($sformatf("strobes_%04h_c%0d", ins, i), 32'(obs()), 32'(q[i]));
            if (i == 2 && op != 4'hE && op != 4'hF) begin
                chk($sformatf("out_sel_%04h", ins), 32'(bus.alu_out_select),
                    32'((op == 4'hC || op == 4'hD) ? 4'h0 : d));
                chk($sformatf("alu_op_%04h", ins), 32'(bus.alu_op),
                    32'((op < 4'h8) ? op : (op >= 4'h9 && op <= 4'hB) ? 4'h0 : 4'hF));
                if (op != 4'h8)
                    chk($sformatf("a_sel_%04h", ins), 32'(bus.alu_a_select), 32'(a));
                if (op == 4'h8) begin
                    chk($sformatf("a_alt_%04h", ins), 32'(bus.alu_a_altern), {24'h0, ins[7:0]});
                    chk($sformatf("a_src_%04h", ins), 32'(bus.alu_a_source), 32'h1);
                end
                if (op < 4'h8) begin
                    chk($sformatf("b_sel_%04h", ins), 32'(bus.alu_b_select), 32'(b));
                    chk($sformatf("srcs_%04h", ins), {bus.alu_a_source, bus.alu_b_source}, 32'h0);
                end
            end
            if (op == 4'hE && i >= plot0 && i <= plot0 + wt)
                chk($sformatf("vga_sel_%04h", ins), {bus.vga_color_select, bus.vga_coord_select},
                    32'({d, a}));
            bus.vga_ready = (op == 4'hE && i == plot0 + wt);
            if (drop_run && i == 1) bus.run = 1'b0;
        end
    endtask

    initial begin
        bit st;
        logic [15:0] ins;
        bus.run = 1'b0;
        bus.current_instruction = '0;
        bus.zeroflag  = '0;
        bus.signflag  = '0;
        bus.errorbit  = '0;
        bus.vga_ready = 1'b0;
        resetn = 1'b0;
        restart();

        do_instr(16'h8305, 16'h0, 16'h0, 16'h0, 0, 0, st);
        do_instr(16'h9240, 16'h0, 16'h0, 16'h0, 0, 0, st);
        do_instr(16'hC170, 16'h0002, 16'h0, 16'h0, 0, 0, st);
        do_instr(16'hC170, 16'h0000, 16'h0, 16'h0, 0, 0, st);
        do_instr(16'hD2A0, 16'h0, 16'h0004, 16'h0, 0, 0, st);
        do_instr(16'hE560, 16'h0, 16'h0, 16'h0, 3, 0, st);
        do_instr(16'hB310, 16'h0, 16'h0, 16'h0, 0, 1, st);

        // run dropped mid-instruction: sequencer parks idle after writeback
        repeat (2) begin
            @(negedge clock);
            chk("idle_after_run_drop", 32'(obs()), 32'h0);
        end
        bus.run = 1'b1;

        // reset during the store's EXEC cycle must kill the strobe at once
        @(negedge clock);
        bus.current_instruction = 16'hA210;
        @(negedge clock);
        @(negedge clock);
        chk("store_exec", 32'(bus.alu_store_to_mem), 32'h1);
        resetn = 1'b0;
        @(negedge clock);
        chk("store_reset_cut", 32'(obs()), 32'h0);
        bus.run = 1'b0;
        resetn  = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk("idle_after_reset", 32'(obs()), 32'h0);
        end
        bus.run = 1'b1;

        do_instr(16'h1312, 16'h0, 16'h0, 16'h0008, 0, 0, st);
        if (st) restart();

        for (int n = 0; n < 120; n++) begin
            ins = 16'($urandom);
            do_instr(ins, 16'($urandom), 16'($urandom), 16'($urandom & $urandom & $urandom),
                     int'($urandom_range(0, 3)), 0, st);
            if (st) restart();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the stimulus");
        $fatal(1, "watchdog expired");
    end
endmodule
